// File: rtl/plb_lookup_stage_mo.sv
// Multi-outstanding PLB lookup stage: in-order tag lookups, stall, flush with response draining, sticky error.
// Optional saturating hit/miss counters under `PLB_LOOKUP_PERF_CNT_EN; output path is registered (min latency 2).
package mpt_pkg;
  typedef enum logic [1:0] {
    MPT_WALKING_DO   = 2'd0,
    MPT_WALKING_SKIP = 2'd1,
    MPT_WALKING_DONE = 2'd2,
    MPT_WALKING_ERR  = 2'd3
  } mpt_walking_e;

  typedef struct packed {
    logic [5:0] SDID;
  } mmpt_t;

  typedef struct packed {
    mmpt_t        mmpt;
    logic [21:0]  spa;
    logic [1:0]   access_type;
    mpt_walking_e walking;
  } mptw_transaction_t;

  typedef struct packed {
    logic [5:0]  SDID;
    logic [21:0] spa;
    logic [1:0]  access_type;
  } plb_lookup_req_t;
endpackage

module plb_lookup_stage_mo
  import mpt_pkg::*;
#(
  parameter int PIPELINE_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int HIT_BIT             = 0,
  localparam int PLB_ADDR_WIDTH     = $bits(plb_lookup_req_t),
  localparam int PLB_DATA_WIDTH     = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [PIPELINE_DATA_WIDTH-1:0] s_data_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [PIPELINE_DATA_WIDTH-1:0] m_data_o,
  input  logic                           stall_i,
  input  logic                           flush_i,
  output logic                           busy_o,
  output logic                           err_o,
  output logic                           plb_cache_mem_req,
  input  logic                           plb_cache_mem_gnt,
  output logic [PLB_ADDR_WIDTH-1:0]      plb_cache_mem_addr,
  output logic                           plb_cache_mem_we,
  output logic [PLB_DATA_WIDTH-1:0]      plb_cache_mem_wdata,
  output logic [PLB_DATA_WIDTH/8-1:0]    plb_cache_mem_be,
  input  logic                           plb_cache_mem_valid,
  input  logic [PLB_DATA_WIDTH-1:0]      plb_cache_mem_rdata,
  output logic [31:0]                    hit_cnt_o,
  output logic [31:0]                    miss_cnt_o
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $bits(mptw_transaction_t);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  mptw_transaction_t          r_txq [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_hq;
  ptr_t r_tx_wp, r_tx_rp, r_hq_wp, r_hq_rp;
  cnt_t r_occ, r_hq_cnt, r_discard;
  logic r_err;

  mptw_transaction_t w_s_txn, w_out;
  plb_lookup_req_t   w_lookup;
  cnt_t w_pend;
  logic w_can_issue, w_accept, w_pop, w_tx_ne, w_hq_ne;
  logic w_rsp_drop, w_rsp_err, w_rsp_keep;
  logic w_unused_rdata;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_s_txn              = mptw_transaction_t'(s_data_i[TW-1:0]);
  assign w_lookup.SDID        = w_s_txn.mmpt.SDID;
  assign w_lookup.spa         = w_s_txn.spa;
  assign w_lookup.access_type = w_s_txn.access_type;

  assign w_pend      = r_occ - r_hq_cnt;
  assign w_tx_ne     = (r_occ != '0);
  assign w_hq_ne     = (r_hq_cnt != '0);
  assign w_can_issue = ~rst_i & ~stall_i & ~flush_i & (r_discard == '0)
                     & (r_occ < cnt_t'(MAX_OUTSTANDING));

  assign plb_cache_mem_req   = s_valid_i & w_can_issue;
  assign plb_cache_mem_addr  = plb_cache_mem_req ? w_lookup : '0;
  assign plb_cache_mem_we    = 1'b0;
  assign plb_cache_mem_wdata = '0;
  assign plb_cache_mem_be    = '0;
  assign s_ready_o           = w_can_issue & plb_cache_mem_gnt;
  assign w_accept            = plb_cache_mem_req & plb_cache_mem_gnt;

  assign w_rsp_drop = plb_cache_mem_valid & (r_discard != '0);
  assign w_rsp_err  = plb_cache_mem_valid & (r_discard == '0) & (w_pend == '0);
  assign w_rsp_keep = plb_cache_mem_valid & (r_discard == '0) & (w_pend != '0);
  assign w_unused_rdata = &{1'b0, plb_cache_mem_rdata};

  assign m_valid_o = w_tx_ne & w_hq_ne & ~stall_i & ~flush_i;
  assign w_pop     = m_valid_o & m_ready_i;

  always_comb begin
    w_out         = r_txq[r_tx_rp];
    w_out.walking = r_hq[r_hq_rp] ? MPT_WALKING_SKIP : MPT_WALKING_DO;
    if (!(w_tx_ne && w_hq_ne)) w_out = '0;
  end

  assign m_data_o = PIPELINE_DATA_WIDTH'(w_out);
  assign busy_o   = w_tx_ne | (r_discard != '0);
  assign err_o    = r_err;

  // Storage needs no reset: occupancy counters alone define validity.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_txq[r_tx_wp] <= w_s_txn;
    if (w_rsp_keep && !flush_i) r_hq[r_hq_wp] <= plb_cache_mem_rdata[HIT_BIT];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_hq_wp   <= '0;
      r_hq_rp   <= '0;
      r_occ     <= '0;
      r_hq_cnt  <= '0;
      r_discard <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_rsp_err) r_err <= 1'b1;
      if (flush_i) begin
        r_tx_wp  <= '0;
        r_tx_rp  <= '0;
        r_hq_wp  <= '0;
        r_hq_rp  <= '0;
        r_occ    <= '0;
        r_hq_cnt <= '0;
        // A response landing in the flush cycle already answers one of the pending lookups.
        r_discard <= r_discard + w_pend - cnt_t'(w_rsp_drop | w_rsp_keep);
      end else begin
        if (w_accept)   r_tx_wp <= ptr_inc(r_tx_wp);
        if (w_rsp_keep) r_hq_wp <= ptr_inc(r_hq_wp);
        if (w_pop) begin
          r_tx_rp <= ptr_inc(r_tx_rp);
          r_hq_rp <= ptr_inc(r_hq_rp);
        end
        r_occ    <= r_occ + cnt_t'(w_accept) - cnt_t'(w_pop);
        r_hq_cnt <= r_hq_cnt + cnt_t'(w_rsp_keep) - cnt_t'(w_pop);
        if (w_rsp_drop) r_discard <= r_discard - 1'b1;
      end
    end
  end

`ifdef PLB_LOOKUP_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_pop) begin
      if (w_out.walking == MPT_WALKING_SKIP) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_plb_lookup_stage_mo.sv
// Directed self-checking bench for plb_lookup_stage_mo (MAX_OUTSTANDING=4).
module tb_plb_lookup_stage_mo;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready, stall, flush, busy, err;
  logic [31:0] s_data, m_data;
  logic        mem_req, mem_gnt, mem_we, mem_valid;
  logic [29:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [0:0]  mem_be;
  logic [31:0] hit_cnt, miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] t1;
  logic [31:0] t2 [5];
  logic [31:0] t3 [3];
  logic [31:0] t4 [2];
  logic [7:0]  rd2 [4];
  logic        h2 [4];
  logic [31:0] exp_hits, exp_miss;

  plb_lookup_stage_mo #(
    .PIPELINE_DATA_WIDTH(32),
    .MAX_OUTSTANDING(4),
    .HIT_BIT(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .stall_i(stall), .flush_i(flush), .busy_o(busy), .err_o(err),
    .plb_cache_mem_req(mem_req), .plb_cache_mem_gnt(mem_gnt),
    .plb_cache_mem_addr(mem_addr), .plb_cache_mem_we(mem_we),
    .plb_cache_mem_wdata(mem_wdata), .plb_cache_mem_be(mem_be),
    .plb_cache_mem_valid(mem_valid), .plb_cache_mem_rdata(mem_rdata),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walking field is set to 2'b11 on input so the overwrite is visible.
  function automatic logic [31:0] mk(input logic [5:0] sdid, input logic [21:0] spa,
                                     input logic [1:0] at);
    return {sdid, spa, at, 2'b11};
  endfunction

  function automatic logic [31:0] exp_out(input logic [31:0] t, input logic hit);
    return {t[31:2], 1'b0, hit};
  endfunction

  initial begin
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hFFFF_FFFF; m_ready = 1'b0;
    stall = 1'b0; flush = 1'b0; mem_gnt = 1'b1; mem_valid = 1'b0; mem_rdata = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    s_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Minimum latency: accept N, response N+1, output N+2.
    t1 = mk(6'h15, 22'h12345, 2'b10);
    s_data = t1; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    check("t1_s_ready", {31'd0, s_ready}, 32'd1);
    check("t1_req", {31'd0, mem_req}, 32'd1);
    check("t1_addr", {2'b00, mem_addr}, {2'b00, 6'h15, 22'h12345, 2'b10});
    check("t1_we_wdata_be", {22'd0, mem_we, mem_wdata, mem_be}, 32'd0);
    tick();
    s_valid = 1'b0; mem_valid = 1'b1; mem_rdata = 8'h01;
    #1;
    check("t1_mv_n1", {31'd0, m_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_addr_idle", {2'b00, mem_addr}, 32'd0);
    tick();
    mem_valid = 1'b0;
    check("t1_mv_n2", {31'd0, m_valid}, 32'd1);
    check("t1_data", m_data, exp_out(t1, 1'b1));
    tick();
    check("t1_mv_after", {31'd0, m_valid}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // Fill to MAX_OUTSTANDING with output blocked; fifth is refused.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) t2[i] = mk(6'(i + 1), 22'(256 + i), 2'(i));
    for (int i = 0; i < 5; i++) begin
      s_data = t2[i]; s_valid = 1'b1;
      #1;
      check($sformatf("t2_rdy%0d", i), {31'd0, s_ready}, (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    s_valid = 1'b0;
    #1;
    check("t2_busy", {31'd0, busy}, 32'd1);
    rd2[0] = 8'hFE; rd2[1] = 8'h01; rd2[2] = 8'hFF; rd2[3] = 8'h00;
    h2[0] = 1'b0;   h2[1] = 1'b1;   h2[2] = 1'b1;   h2[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_rdata = rd2[k];
      tick();
    end
    mem_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_mv%0d", k), {31'd0, m_valid}, 32'd1);
      check($sformatf("t2_data%0d", k), m_data, exp_out(t2[k], h2[k]));
      tick();
    end
    check("t2_mv_end", {31'd0, m_valid}, 32'd0);
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_err", {31'd0, err}, 32'd0);

    // Flush with three lookups in flight; their responses are drained.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) t3[i] = mk(6'h30, 22'(i), 2'b01);
    for (int i = 0; i < 3; i++) begin
      s_data = t3[i]; s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    check("t3_busy_pre", {31'd0, busy}, 32'd1);
    flush = 1'b1; s_valid = 1'b1;
    #1;
    check("t3_rdy_flush", {31'd0, s_ready}, 32'd0);
    check("t3_req_flush", {31'd0, mem_req}, 32'd0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_rdata = 8'h01;
      #1;
      check($sformatf("t3_rdy%0d", k), {31'd0, s_ready}, 32'd0);
      check($sformatf("t3_mv%0d", k), {31'd0, m_valid}, 32'd0);
      check($sformatf("t3_busy%0d", k), {31'd0, busy}, 32'd1);
      tick();
    end
    mem_valid = 1'b0;
    #1;
    check("t3_busy_end", {31'd0, busy}, 32'd0);
    check("t3_rdy_end", {31'd0, s_ready}, 32'd1);
    check("t3_mv_end", {31'd0, m_valid}, 32'd0);
    check("t3_err", {31'd0, err}, 32'd0);

    // Stall for five cycles while both responses arrive.
    m_ready = 1'b1;
    t4[0] = mk(6'h0A, 22'h3AAAA, 2'b00);
    t4[1] = mk(6'h0B, 22'h05555, 2'b11);
    for (int i = 0; i < 2; i++) begin
      s_data = t4[i]; s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_valid = (c < 2);
      mem_rdata = (c == 0) ? 8'h01 : 8'hFE;
      #1;
      check($sformatf("t4_mv_stall%0d", c), {31'd0, m_valid}, 32'd0);
      check($sformatf("t4_rdy_stall%0d", c), {31'd0, s_ready}, 32'd0);
      tick();
    end
    mem_valid = 1'b0; stall = 1'b0;
    #1;
    check("t4_mv0", {31'd0, m_valid}, 32'd1);
    check("t4_data0", m_data, exp_out(t4[0], 1'b1));
    tick();
    check("t4_mv1", {31'd0, m_valid}, 32'd1);
    check("t4_data1", m_data, exp_out(t4[1], 1'b0));
    tick();
    check("t4_mv_end", {31'd0, m_valid}, 32'd0);
    check("t4_busy_end", {31'd0, busy}, 32'd0);

`ifdef PLB_LOOKUP_PERF_CNT_EN
    exp_hits = 32'd4; exp_miss = 32'd3;
`else
    exp_hits = 32'd0; exp_miss = 32'd0;
`endif
    check("cnt_hit", hit_cnt, exp_hits);
    check("cnt_miss", miss_cnt, exp_miss);

    // Unsolicited response sets the sticky error.
    check("t5_err_pre", {31'd0, err}, 32'd0);
    mem_valid = 1'b1; mem_rdata = 8'h01;
    tick();
    mem_valid = 1'b0;
    check("t5_err_set", {31'd0, err}, 32'd1);
    check("t5_mv", {31'd0, m_valid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_err_rst", {31'd0, err}, 32'd0);
    check("t5_hit_rst", hit_cnt, 32'd0);
    check("t5_miss_rst", miss_cnt, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_err_post", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
